smart_led_frame_sequencer: RTL
==============================

Name: smart_led_frame_sequencer

Overview:
- Host-side frame generator that drives the smart-LED protocol receiver inputs: frame, bit clock, serial data and the 5-bit bit counter.
- Accepts 31-bit LED words over a valid/ready stream, appends an even-parity bit 31 and serialises each word bit 0 first.
- Inserts lead, tail and inter-frame gap timing so the receiver latches PWM values on frame fall.
- Sits between the test/host logic and the chain input (DIN/BIN pins or on-chip protocol instance).

Parameters:
- CLK_DIV, 4: system clocks per bit period; legal range 2..255.
- GAP_CYCLES, 8: clocks with frame low between two frames; legal range 1..255.
- CNT_W, 8: width of the words-sent counter.

Ports:
- clk, input, 1: global clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- s_valid, input, 1: host word valid.
- s_ready, output, 1: sequencer accepts the word this cycle (transfer = s_valid & s_ready).
- s_word, input, 31: frame bits 0..30; bit 0 is the start/marker bit.
- s_last, input, 1: word is the last of the frame.
- s_bad_parity, input, 1: invert the generated parity bit (error injection).
- frame_o, output, 1: frame envelope (receiver in_frame).
- bit_clk_o, output, 1: one-cycle strobe per bit (receiver in_clk).
- data_o, output, 1: serial data bit.
- bit_counter_o, output, 5: index of the bit currently on data_o.
- busy, output, 1: state is not IDLE.
- underrun, output, 1: one-cycle pulse when the frame is aborted for lack of data.
- words_sent, output, CNT_W: words fully serialised since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at posedge, including mid-frame): state IDLE, and all of the following clear on that same edge: frame_o, bit_clk_o, data_o, bit_counter_o, underrun, words_sent, parity and the shift register. s_ready=1 only in IDLE, so it is 1 after reset.
- Parity: P = XOR(s_word[30:0]) ^ s_bad_parity. Transmitted bit 31 = P, so the XOR of all 32 bits is 0 unless injected.
- Bit timing: each bit occupies exactly CLK_DIV clocks.
  - data_o and bit_counter_o update on the first clock of the period and stay stable for the whole period.
  - bit_clk_o is 1 only on the last clock of the period. It must never be high for two consecutive cycles, because the receiver acts on every high cycle.
- States:
  - IDLE: frame_o=0, s_ready=1. On a transfer, latch word, s_last and parity; go to LEAD.
  - LEAD: frame_o=1, bit_clk_o=0, data_o=0, for CLK_DIV clocks; then go to SHIFT with bit_counter_o=0.
  - SHIFT: serialise bits 0..31 with bit_counter_o = bit index. On the clock that strobes bit 31, increment words_sent.
    - If the word is last: go to TAIL.
    - Otherwise assert s_ready on that same clock only. On a transfer, load the next word so its bit 0 starts on the next clock with no gap. With no transfer, pulse underrun, drop frame_o next clock and go to GAP.
  - TAIL: frame_o=1, no strobes, for CLK_DIV clocks; then frame_o falls and state goes to GAP.
  - GAP: frame_o=0 for GAP_CYCLES clocks; then IDLE. s_ready stays 0 throughout GAP.
- Outside SHIFT: bit_clk_o=0, data_o=0, bit_counter_o=0.
- Host interface: s_word, s_last and s_bad_parity are sampled only on a transfer. Changes to them while s_ready=0 are ignored.
- Latency: a transfer in IDLE gives frame_o=1 on the next clock. The first bit_clk_o comes 2*CLK_DIV clocks after the transfer edge.
- Simultaneous rst and transfer: reset wins and the word is dropped.
- words_sent at 2^CNT_W-1 wraps to 0.

Decomposition:
- Shared package smart_led_pkg holds:
  - FRAME_BITS=32, PARITY_BIT=31, MARKER_BIT=0.
  - The state enumeration: IDLE, LEAD, SHIFT, TAIL, GAP.
- One sub-module, smart_led_bit_timer: CLK_DIV down-counter emitting period_start and period_end strobes. It is reused for the LEAD and TAIL lengths.
- Parity and shift register stay inline.

Test Plan:
- Single frame: CLK_DIV=4; transfer word 31'h0000_0001 with s_last=1.
  - Expect frame_o high for 4+128+4 clocks, then 8 low.
  - Expect 32 strobes, data_o=1 only at bit 0, and bit 31=1.
  - Expect words_sent=1.
- Two-word back-to-back BIN frame: words 31'h7FFF_FFFF then 31'h0000_0003 (last).
  - Expect 64 strobes with no idle period between bit 31 and the next bit 0.
  - Parity bits: 1 then 0.
  - bit_counter_o sequence 0..31, 0..31.
- Underrun: first word s_last=0 and s_valid held low afterwards.
  - Expect underrun pulse exactly one clock after the bit-31 strobe.
  - frame_o falls the next clock; busy stays high for GAP_CYCLES clocks, then drops.
- Error injection: word 31'h0000_0001 with s_bad_parity=1.
  - Expect bit 31=0.
  - Connected protocol receiver (DIN mode) asserts error and never pwm_set.
- Reset mid-frame: assert rst at bit 12 of the first word.
  - Next clock: all outputs 0, s_ready=1, words_sent=0.
  - A new frame then starts cleanly.
- Strobe width: sweep CLK_DIV=2 and 7. Check bit_clk_o is never high two consecutive cycles and the period is exactly CLK_DIV.

Source files
------------

// File: rtl/smart_led_pkg.sv
// smart_led_pkg
// Shared definitions for the smart-LED frame sequencer: frame geometry,
// FSM state encodings and the parity helper used when a word is accepted.
package smart_led_pkg;

   localparam int FRAME_BITS = 32;   // 31 payload bits + parity
   localparam int PARITY_BIT = 31;   // last bit on the wire
   localparam int MARKER_BIT = 0;    // first bit on the wire (start/marker)

   // Sequencer states
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEAD  = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_TAIL  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   // Even parity over the payload, optionally inverted for error injection.
   function automatic logic frame_parity(input logic [30:0] word, input logic invert);
      return (^word) ^ invert;
   endfunction

endpackage

// File: rtl/smart_led_bit_timer.sv
// smart_led_bit_timer
// Free-running CLK_DIV phase counter used to pace LEAD, every SHIFT bit and
// TAIL. While run=0 the phase is held at 0 so the next period starts cleanly.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   run           - count while high, hold phase 0 while low
//   period_start  - current clock is the first of a period
//   period_end    - current clock is the last of a period
module smart_led_bit_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic period_start,
   output logic period_end
);

   localparam int PW = $clog2(CLK_DIV);

   logic [PW-1:0] phase_reg;

   assign period_start = run && (phase_reg == '0);
   assign period_end   = run && (phase_reg == PW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         phase_reg <= '0;
      end else if (period_end) begin
         phase_reg <= '0;
      end else begin
         phase_reg <= phase_reg + PW'(1);
      end
   end

endmodule

// File: rtl/smart_led_frame_sequencer.sv
// smart_led_frame_sequencer
// Turns a valid/ready stream of 31-bit LED words into the receiver's
// frame / bit clock / data / bit-counter signals. Each word gets an even
// parity bit 31 and is sent bit 0 first, framed by LEAD and TAIL periods
// and followed by a GAP with frame low.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   s_valid/s_ready         - input word handshake
//   s_word, s_last          - payload bits 0..30, last word of frame
//   s_bad_parity            - invert generated parity bit
//   frame_o, bit_clk_o      - frame envelope, one-cycle strobe per bit
//   data_o, bit_counter_o   - serial bit and its index
//   busy, underrun          - not idle, frame aborted for lack of data
//   words_sent              - words fully serialised (wraps)
module smart_led_frame_sequencer
   import smart_led_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [30:0]      s_word,
   input  logic             s_last,
   input  logic             s_bad_parity,
   output logic             frame_o,
   output logic             bit_clk_o,
   output logic             data_o,
   output logic [4:0]       bit_counter_o,
   output logic             busy,
   output logic             underrun,
   output logic [CNT_W-1:0] words_sent
);

   logic [2:0]            state_reg;
   logic [FRAME_BITS-1:0] shift_reg;
   logic [4:0]            bit_idx_reg;
   logic                  last_reg;
   logic [8:0]            gap_cnt_reg;
   logic                  underrun_reg;
   logic [CNT_W-1:0]      words_reg;

   logic                  run;
   logic                  period_start;
   logic                  period_end;
   logic                  word_end;
   logic                  xfer;
   logic [FRAME_BITS-1:0] load_word;

   assign run = (state_reg == S_LEAD) || (state_reg == S_SHIFT) || (state_reg == S_TAIL);

   smart_led_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .period_start (period_start),
      .period_end   (period_end)
   );

   // Last clock of the parity bit: the only mid-frame point where a new word
   // may be taken, so the next bit 0 follows with no gap.
   assign word_end  = (state_reg == S_SHIFT) && period_end && (bit_idx_reg == 5'(PARITY_BIT));
   assign s_ready   = (state_reg == S_IDLE) || (word_end && !last_reg);
   assign xfer      = s_valid && s_ready;
   assign load_word = {frame_parity(s_word, s_bad_parity), s_word};

   // The shift register is shifted right, so the bit on the wire always sits
   // at the marker position. The extra !period_start term keeps the strobe
   // from ever covering a whole period.
   assign bit_clk_o     = (state_reg == S_SHIFT) && period_end && !period_start;
   assign data_o        = (state_reg == S_SHIFT) && shift_reg[MARKER_BIT];
   assign bit_counter_o = (state_reg == S_SHIFT) ? bit_idx_reg : 5'd0;
   // After an underrun the GAP counter is preloaded one higher; that first
   // GAP clock keeps frame high while underrun pulses.
   assign frame_o       = run || ((state_reg == S_GAP) && (gap_cnt_reg > 9'(GAP_CYCLES)));
   assign busy          = (state_reg != S_IDLE);
   assign underrun      = underrun_reg;
   assign words_sent    = words_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         shift_reg    <= '0;
         bit_idx_reg  <= '0;
         last_reg     <= 1'b0;
         gap_cnt_reg  <= '0;
         underrun_reg <= 1'b0;
         words_reg    <= '0;
      end else begin
         underrun_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (xfer) begin
                  shift_reg   <= load_word;
                  last_reg    <= s_last;
                  bit_idx_reg <= '0;
                  state_reg   <= S_LEAD;
               end
            end
            S_LEAD: begin
               if (period_end) begin
                  state_reg <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (word_end) begin
                  words_reg <= words_reg + CNT_W'(1);
                  if (last_reg) begin
                     state_reg <= S_TAIL;
                  end else if (xfer) begin
                     shift_reg   <= load_word;
                     last_reg    <= s_last;
                     bit_idx_reg <= '0;
                  end else begin
                     underrun_reg <= 1'b1;
                     gap_cnt_reg  <= 9'(GAP_CYCLES + 1);
                     state_reg    <= S_GAP;
                  end
               end else if (period_end) begin
                  shift_reg   <= {1'b0, shift_reg[FRAME_BITS-1:1]};
                  bit_idx_reg <= bit_idx_reg + 5'd1;
               end
            end
            S_TAIL: begin
               if (period_end) begin
                  gap_cnt_reg <= 9'(GAP_CYCLES);
                  state_reg   <= S_GAP;
               end
            end
            S_GAP: begin
               gap_cnt_reg <= gap_cnt_reg - 9'd1;
               if (gap_cnt_reg == 9'd1) begin
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule
